// File: rtl/significand_pack_if.sv
// Operand/result bundle for significand_pack: operand handshake in, packed-word handshake out.
`timescale 1ns/1ps
interface significand_pack_if #(parameter int N = 64);
   logic          in_valid;
   logic          in_ready;
   logic          dbs;
   logic          s;
   logic [10:0]   e;
   logic [52:0]   f;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  x;
   logic [5:0]    shifts;
   logic          zero;

   modport slave (
      input  in_valid, dbs, s, e, f, out_ready,
      output in_ready, out_valid, x, shifts, zero
   );

   modport master (
      output in_valid, dbs, s, e, f, out_ready,
      input  in_ready, out_valid, x, shifts, zero
   );
endinterface

// File: rtl/significand_pack.sv
// Normalizes a 1.52 significand one left-shift per cycle, then packs an IEEE double/single word.
// Result valid k+1 cycles after accept (k = shifts); result held until out_ready, one operand in flight.
`timescale 1ns/1ps
module significand_pack #(
   parameter int N = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   significand_pack_if.slave bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, NORM = 2'd1, DONE = 2'd2} state_t;

   state_t        r_state;
   state_t        w_next;
   logic          r_s;
   logic          r_dbs;
   logic [10:0]   r_e;
   logic [52:0]   r_f;
   logic [5:0]    r_cnt;
   logic [N-1:0]  r_x;
   logic          r_zero;

   logic [10:0]   w_emax;
   logic [10:0]   w_expf;
   logic          w_shift;
   logic          w_load;
   logic          w_step;
   logic          w_pack;
   logic [N-1:0]  w_word;

   // Shifting stops at the hidden bit, at the minimum exponent (denormal), or for Inf/NaN.
   always_comb begin
      w_emax  = r_dbs ? 11'h0FF : 11'h7FF;
      w_shift = !r_f[52] && (r_f != '0) && (r_e > 11'd1) && (r_e != w_emax)
                && (r_cnt != 6'd52);
      w_expf  = (r_f[52] || (r_e == w_emax)) ? r_e : 11'd0;
      if (r_f == '0) begin
         w_word = {r_s, {(N-1){1'b0}}};
      end else if (r_dbs) begin
         w_word = {r_s, w_expf[7:0], r_f[51:29], 32'h0};
      end else begin
         w_word = {r_s, w_expf, r_f[51:0]};
      end
   end

   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      w_step = 1'b0;
      w_pack = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.in_valid) begin
               w_load = 1'b1;
               w_next = NORM;
            end
         end
         NORM: begin
            if (w_shift) begin
               w_step = 1'b1;
            end else begin
               w_pack = 1'b1;
               w_next = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_s     <= 1'b0;
         r_dbs   <= 1'b0;
         r_e     <= 11'd0;
         r_f     <= 53'd0;
         r_cnt   <= 6'd0;
         r_x     <= '0;
         r_zero  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_load) begin
            r_s   <= bus.s;
            r_dbs <= bus.dbs;
            r_e   <= (bus.e == 11'd0) ? 11'd1 : bus.e;
            r_f   <= bus.f;
            r_cnt <= 6'd0;
         end
         if (w_step) begin
            r_f   <= {r_f[51:0], 1'b0};
            r_e   <= r_e - 11'd1;
            r_cnt <= r_cnt + 6'd1;
         end
         if (w_pack) begin
            r_x    <= w_word;
            r_zero <= (r_f == '0);
         end
      end
   end

   assign bus.in_ready  = (r_state == IDLE);
   assign bus.out_valid = (r_state == DONE);
   assign bus.x         = r_x;
   assign bus.shifts    = r_cnt;
   assign bus.zero      = r_zero;

endmodule

// File: tb/tb_significand_pack.sv
// Randomized + directed scoreboard bench for significand_pack against an arithmetic reference model.
`timescale 1ns/1ps
module tb_significand_pack;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   significand_pack_if #(.N(64)) bus ();
   significand_pack #(.N(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {
      logic [63:0] x;
      int          shifts;
      logic        zero;
      int          acc;
   } exp_t;

   exp_t sbq[$];
   int   checks   = 0;
   int   errors   = 0;
   int   cyc      = 0;
   int   min_hold = 0;
   bit   seen     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Leading-zero count clipped by the exponent headroom, then IEEE field assembly.
   function automatic exp_t model(input logic dbs, input logic s,
                                  input logic [10:0] e, input logic [52:0] f);
      exp_t        r;
      int          ee;
      int          emax;
      int          k;
      int          msb;
      logic [52:0] ff;
      logic [10:0] ef;
      ee   = (e == 0) ? 1 : int'(e);
      emax = dbs ? 255 : 2047;
      ff   = f;
      k    = 0;
      if (f != 0 && ee != emax) begin
         msb = 0;
         for (int i = 0; i < 53; i++) if (f[i]) msb = i;
         k = 52 - msb;
         if (k > ee - 1) k = ee - 1;
         ff = f << k;
         ee = ee - k;
      end
      ef = (ff[52] || ee == emax) ? 11'(ee) : 11'd0;
      if (f == 0)   r.x = {s, 63'd0};
      else if (dbs) r.x = {s, ef[7:0], ff[51:29], 32'h0};
      else          r.x = {s, ef, ff[51:0]};
      r.shifts = k;
      r.zero   = (f == 0);
      r.acc    = 0;
      return r;
   endfunction

   task automatic present(input logic dbs, input logic s, input logic [10:0] e,
                          input logic [52:0] f, output bit ok);
      int n;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.dbs = dbs; bus.s = s; bus.e = e; bus.f = f;
      n = 0;
      while (!bus.in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      ok = bus.in_ready;
      if (!ok) begin
         checks++; errors++;
         $display("FAIL accept_timeout actual=in_ready 0 required=in_ready 1");
      end
   endtask

   task automatic finish_accept();
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic send_exp(input logic dbs, input logic s, input logic [10:0] e,
                           input logic [52:0] f, input logic [63:0] xe,
                           input int she, input logic ze);
      bit   ok;
      exp_t r;
      present(dbs, s, e, f, ok);
      if (ok) begin
         r.x = xe; r.shifts = she; r.zero = ze; r.acc = cyc + 1;
         sbq.push_back(r);
      end
      finish_accept();
   endtask

   task automatic send_model(input logic dbs, input logic s, input logic [10:0] e,
                             input logic [52:0] f);
      bit   ok;
      exp_t r;
      present(dbs, s, e, f, ok);
      if (ok) begin
         r = model(dbs, s, e, f);
         r.acc = cyc + 1;
         sbq.push_back(r);
      end
      finish_accept();
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (sbq.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout actual=%0d pending required=0", sbq.size());
         sbq.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin : monitor
      int vcyc;
      int hold_req;
      vcyc = 0;
      hold_req = 0;
      bus.out_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            bus.out_ready = 1'b0;
         end else if (bus.out_valid) begin
            if (sbq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_out actual=out_valid 1 x=%h required=out_valid 0", bus.x);
               bus.out_ready = 1'b1;
            end else begin
               if (!seen) begin
                  check("latency", 64'(cyc - sbq[0].acc), 64'(sbq[0].shifts + 1));
                  check("x", bus.x, sbq[0].x);
                  check("shifts", 64'(bus.shifts), 64'(sbq[0].shifts));
                  check("zero", 64'(bus.zero), 64'(sbq[0].zero));
                  seen = 1;
                  vcyc = 0;
                  hold_req = min_hold;
               end else begin
                  check("hold_x", bus.x, sbq[0].x);
                  check("hold_shifts", 64'(bus.shifts), 64'(sbq[0].shifts));
               end
               check("in_ready_busy", 64'(bus.in_ready), 64'd0);
               vcyc++;
               if (vcyc > hold_req && $urandom_range(0, 1) == 1) begin
                  bus.out_ready = 1'b1;
                  void'(sbq.pop_front());
                  seen = 0;
               end else begin
                  bus.out_ready = 1'b0;
               end
            end
         end else begin
            bus.out_ready = ($urandom_range(0, 3) == 0);
         end
      end
   end

   initial begin : watchdog
      #5ms;
      errors++;
      $display("FAIL watchdog actual=timeout required=completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : stim
      bit ok;
      logic [63:0] rnd;
      logic [52:0] fr;
      logic        db;
      logic [10:0] er;
      int          mode;
      bus.in_valid = 1'b0;
      bus.dbs = 1'b0; bus.s = 1'b0; bus.e = '0; bus.f = '0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_x", bus.x, 64'd0);
      check("rst_shifts", 64'(bus.shifts), 64'd0);
      check("rst_zero", 64'(bus.zero), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);

      send_exp(1'b0, 1'b0, 11'h3FF, 53'd1 << 52, 64'h3FF0000000000000, 0, 1'b0);
      send_exp(1'b0, 1'b0, 11'h3FF, 53'd1 << 50, 64'h3FD0000000000000, 2, 1'b0);
      send_exp(1'b0, 1'b0, 11'd3,   53'd1 << 48, 64'h0004000000000000, 2, 1'b0);
      send_exp(1'b0, 1'b1, 11'h400, 53'd0,       64'h8000000000000000, 0, 1'b1);
      send_exp(1'b0, 1'b0, 11'h7FF, 53'd1 << 52, 64'h7FF0000000000000, 0, 1'b0);
      send_exp(1'b0, 1'b1, 11'h7FF, (53'd1 << 52) | 53'd1, 64'hFFF0000000000001, 0, 1'b0);
      send_exp(1'b1, 1'b0, 11'd0,   53'd1 << 52, 64'h0080000000000000, 0, 1'b0);
      send_exp(1'b0, 1'b0, 11'd0,   53'd1 << 51, 64'h0008000000000000, 0, 1'b0);
      send_exp(1'b1, 1'b0, 11'h80,  (53'd1 << 52) | 53'h1FFFFFFF, 64'h4000000000000000, 0, 1'b0);
      drain();

      min_hold = 6;
      send_exp(1'b1, 1'b0, 11'h07F, 53'd1 << 51, 64'h3F00000000000000, 1, 1'b0);
      drain();
      min_hold = 0;

      // Abort an operand mid-normalization; nothing may come out for it.
      present(1'b0, 1'b0, 11'h3FF, 53'd1, ok);
      finish_accept();
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_out_valid", 64'(bus.out_valid), 64'd0);
      check("abort_x", bus.x, 64'd0);
      check("abort_shifts", 64'(bus.shifts), 64'd0);
      sbq.delete();
      seen = 0;
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_in_ready", 64'(bus.in_ready), 64'd1);
      repeat (70) @(negedge clk);
      send_exp(1'b0, 1'b0, 11'h3FF, 53'd1 << 52, 64'h3FF0000000000000, 0, 1'b0);
      drain();

      for (int i = 0; i < 300; i++) begin
         rnd  = {$urandom, $urandom};
         fr   = rnd[52:0];
         mode = $urandom_range(0, 19);
         if (mode == 0)      fr = 53'd0;
         else if (mode < 8)  fr[52] = 1'b1;
         else                fr = fr >> $urandom_range(1, 52);
         db = $urandom_range(0, 1);
         er = db ? 11'($urandom_range(0, 254)) : 11'($urandom_range(0, 2046));
         if ($urandom_range(0, 9) == 0) er = 11'd0;
         send_model(db, 1'($urandom_range(0, 1)), er, fr);
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/significand_pack.md
SIGNIFICAND_PACK -- requirements
Module: significand_pack

Interface
REQ-001 SHALL have parameter N, default 64, meaning the packed word width; only 64 is supported.
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, meaning an asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, meaning an operand is present on s/e/f/dbs.
REQ-005 SHALL have port in_ready, output, 1, meaning the block accepts an operand this cycle.
REQ-006 SHALL have port dbs, input, 1, meaning 1 = single-precision result, 0 = double.
REQ-007 SHALL have port s, input, 1, meaning the sign bit.
REQ-008 SHALL have port e, input, 11, meaning the biased exponent; single uses e[7:0] with e[10:8]=0.
REQ-009 SHALL have port f, input, 53, meaning the significand in 1.52 format (f[52] = hidden bit).
REQ-010 SHALL have port out_valid, output, 1, meaning x, shifts and zero are valid.
REQ-011 SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-012 SHALL have port x, output, N, meaning the packed IEEE word; single occupies x[63:32], with x[31:0]=0.
REQ-013 SHALL have port shifts, output, 6, meaning the number of normalization left-shifts performed.
REQ-014 SHALL have port zero, output, 1, meaning the result is a signed zero.

Function
REQ-015 SHALL implement the FSM states IDLE, NORM and DONE; in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-016 SHALL, in IDLE with in_valid=1, capture s, e, f and dbs, clear the shift counter and go to NORM; it SHALL treat e=0 as e=1.
REQ-017 SHALL, in NORM, shift f left by 1, decrement e and increment shifts each cycle while f[52]=0 AND f!=0 AND e>1 AND e!=emax, where emax is 0x7FF for double and 0xFF for single.
REQ-018 SHALL, in NORM when no shift condition holds, register the packed result and go to DONE in the same edge.
REQ-019 SHALL form the exponent field as e when f[52]=1 and as 0 otherwise (denormal or zero).
REQ-020 SHALL pack double as {s, expfield[10:0], f[51:0]}.
REQ-021 SHALL pack single as {s, expfield[7:0], f[51:29], 32'h0}, truncating with no rounding.
REQ-022 SHALL pass e=emax through unshifted with the fraction intact (Inf/NaN).
REQ-023 SHALL, for f=0, produce zero=1, exponent and fraction 0, sign preserved, and shifts=0.
REQ-024 SHALL deliver the result with latency k+1 cycles from the accept edge to out_valid=1, where k = shifts and k<=52.
REQ-025 SHALL hold x, shifts and zero stable in DONE until out_ready=1, then return to IDLE; it SHALL NOT accept a new operand in that same cycle.
REQ-026 SHALL ignore in_valid outside IDLE and ignore out_ready outside DONE.
REQ-027 SHALL use an integer shift counter that never wraps, with 52 as the maximum.

Reset
REQ-028 SHALL, while rst_n=0, force state=IDLE, in_ready=1 after release, out_valid=0, x=0, shifts=0, zero=0, and clear internal s/e/f.
REQ-029 SHALL, on reset asserted in NORM or DONE, abort the operation and discard the result; the first post-reset accept SHALL behave as if from a clean start.

Verification
REQ-030 SHALL pass this scenario: dbs=0, s=0, e=0x3FF, f=1<<52 -> out_valid 1 cycle after accept, x=0x3FF0000000000000, shifts=0.
REQ-031 SHALL pass this scenario: dbs=0, e=0x3FF, f=1<<50 -> out_valid 3 cycles after accept, x=0x3FD0000000000000, shifts=2.
REQ-032 SHALL pass this scenario: dbs=0, e=3, f=1<<48 -> denormal, x=0x0004000000000000, shifts=2, zero=0.
REQ-033 SHALL pass this scenario: dbs=0, s=1, f=0, e=0x400 -> x=0x8000000000000000, zero=1, shifts=0.
REQ-034 SHALL pass this scenario: dbs=1, e=0x7F, f=1<<51 -> x=0x3F00000000000000, shifts=1; with out_ready=0 for 5 cycles, x stays stable and in_ready stays 0.
REQ-035 SHALL pass this scenario: rst_n pulsed low mid-NORM (e=0x3FF, f=1) -> out_valid never asserts for that operand, and the next operand e=0x3FF, f=1<<52 yields x=0x3FF0000000000000.
